// File: rtl/timer1_peripheral_if.sv
// External-peripheral register bus between the core and Timer1.
// The core acts as master; the peripheral returns registered read data.
interface timer1_peripheral_if;
   logic [8:0] addr;
   logic       rd_en;
   logic       wr_en;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (output addr, output rd_en, output wr_en, output data_in, input data_out);
   modport slave  (input addr, input rd_en, input wr_en, input data_in, output data_out);
endinterface

// File: rtl/timer1_peripheral.sv
// 16-bit Timer1: TMR1L/TMR1H/T1CON on the external-peripheral bus, 1/2/4/8 prescaler, clk or t1cki source.
// Optional macro TMR1_RD16_EN buffers TMR1H on a TMR1L read for coherent 16-bit reads.
module timer1_peripheral #(
   parameter logic [8:0] TMR1L_ADDR = 9'h00E,
   parameter logic [8:0] TMR1H_ADDR = 9'h00F,
   parameter logic [8:0] T1CON_ADDR = 9'h010
) (
   input  logic                 clk,
   input  logic                 rst_n,
   timer1_peripheral_if.slave   bus,
   input  logic                 t1cki,
   output logic                 tmr1_ovf,
   output logic [15:0]          tmr1_val
);

   logic [7:0] tmr1l, tmr1h, t1con;
   logic [2:0] pcnt, ratio_m1;
   logic       sync1, sync2, sync3;
   logic       sel_l, sel_h, sel_con;
   logic       wr_l, wr_h, wr_con;
   logic       tmr1on, tmr1cs, tick, advance, pmatch;
   logic [7:0] rd_mux;
`ifdef TMR1_RD16_EN
   logic [7:0] hbuf;
`endif

   assign tmr1_val = {tmr1h, tmr1l};
   assign tmr1on   = t1con[0];
   assign tmr1cs   = t1con[1];

   assign sel_l   = (bus.addr == TMR1L_ADDR);
   assign sel_h   = (bus.addr == TMR1H_ADDR);
   assign sel_con = (bus.addr == T1CON_ADDR);
   assign wr_l    = bus.wr_en & sel_l;
   assign wr_h    = bus.wr_en & sel_h;
   assign wr_con  = bus.wr_en & sel_con;

   // External edge detect after the 2-flop synchroniser
   assign tick    = tmr1cs ? (sync2 & ~sync3) : 1'b1;
   assign advance = tmr1on & tick;
   assign pmatch  = (pcnt == ratio_m1);

   always_comb begin
      ratio_m1 = 3'd0;
      case (t1con[5:4])
         2'd0: ratio_m1 = 3'd0;
         2'd1: ratio_m1 = 3'd1;
         2'd2: ratio_m1 = 3'd3;
         2'd3: ratio_m1 = 3'd7;
         default: ratio_m1 = 3'd0;
      endcase
   end

   always_comb begin
      rd_mux = 8'h00;
      if (sel_l)
         rd_mux = tmr1l;
      else if (sel_h)
`ifdef TMR1_RD16_EN
         rd_mux = hbuf;
`else
         rd_mux = tmr1h;
`endif
      else if (sel_con)
         rd_mux = t1con;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr1l        <= 8'h00;
         tmr1h        <= 8'h00;
         t1con        <= 8'h00;
         pcnt         <= 3'd0;
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         sync3        <= 1'b0;
         tmr1_ovf     <= 1'b0;
         bus.data_out <= 8'h00;
`ifdef TMR1_RD16_EN
         hbuf         <= 8'h00;
`endif
      end else begin
         sync1    <= t1cki;
         sync2    <= sync1;
         sync3    <= sync2;
         tmr1_ovf <= 1'b0;

         // A byte write takes precedence over a coincident increment, carry included
         if (wr_l || wr_h) begin
            if (wr_l) tmr1l <= bus.data_in;
            if (wr_h) tmr1h <= bus.data_in;
            pcnt <= 3'd0;
         end else if (advance) begin
            if (pmatch) begin
               pcnt           <= 3'd0;
               {tmr1h, tmr1l} <= tmr1_val + 16'd1;
               tmr1_ovf       <= (tmr1_val == 16'hFFFF);
            end else begin
               pcnt <= pcnt + 3'd1;
            end
         end

         if (wr_con)
            t1con <= {2'b00, bus.data_in[5:0]};

         if (bus.rd_en) begin
            bus.data_out <= rd_mux;
`ifdef TMR1_RD16_EN
            if (sel_l) hbuf <= tmr1h;
`endif
         end
      end
   end

endmodule
